// File: rtl/rf_writeback_driver_pkg.sv
// Shared types and constants for the register-file writeback driver slice.
package rf_pkg;

  localparam int unsigned    RF_ADDR_W   = 4;
  localparam int unsigned    RF_NUM_REGS = 16;
  localparam logic [3:0]     RF_PC_REG   = 4'd15;
  localparam int unsigned    RF_DATA_W   = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] dest;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_req_t;

  // Source of the write registered onto the file port at the next edge.
  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'd0,
    ISSUE_DATA = 2'd1,
    ISSUE_PC   = 2'd2
  } rf_issue_e;

  function automatic logic [RF_NUM_REGS-1:0] rf_onehot(input logic [RF_ADDR_W-1:0] idx);
    rf_onehot      = '0;
    rf_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_writeback_driver_if.sv
// Pipeline-facing writeback handshake plus register-file write port bundle.
interface rf_writeback_driver_if #(
  parameter int unsigned DATA_W = 32
);
  import rf_pkg::*;

  logic                   WB_VALID;
  logic                   WB_READY;
  logic [RF_ADDR_W-1:0]   WB_DEST;
  logic [DATA_W-1:0]      WB_DATA;
  logic                   PC_ADV;
  logic [RF_ADDR_W-1:0]   C;
  logic [DATA_W-1:0]      PW;
  logic                   RFLd;
  logic                   PCLd;
  logic [RF_NUM_REGS-1:0] PEND;

  modport master (
    output WB_VALID, WB_DEST, WB_DATA, PC_ADV,
    input  WB_READY, C, PW, RFLd, PCLd, PEND
  );

  modport slave (
    input  WB_VALID, WB_DEST, WB_DATA, PC_ADV,
    output WB_READY, C, PW, RFLd, PCLd, PEND
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Writeback request FIFO; exposes per-entry valid bits and destinations for the
// pending-destination scoreboard.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_push,
  input  rf_wb_req_t                      i_push_req,
  input  logic                            i_pop,
  output rf_wb_req_t                      o_head,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [DEPTH-1:0]                o_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0] o_dest
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rf_wb_req_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_nxt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_valid = r_valid;

  // Push and pop slots can only coincide when empty or full, where one side is blocked.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop)  w_valid_nxt[r_rptr] = 1'b0;
    if (w_push) w_valid_nxt[r_wptr] = 1'b1;
  end

  always_comb begin
    o_dest = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_dest[i] = r_mem[i].dest;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_req;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_nxt;
    end
  end

endmodule

// File: rtl/rf_writeback_driver.sv
// Register-file write-side client: queues writebacks, issues one write per cycle,
// folds in R15 PC-advance writes. Optional same-cycle bypass: RF_WB_BYPASS_EN.
module rf_writeback_driver
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic                  CLK,
  input logic                  RST_N,
  rf_writeback_driver_if.slave wb
);

  rf_wb_req_t                       w_head;
  rf_wb_req_t                       w_push_req;
  logic                             w_full;
  logic                             w_empty;
  logic [DEPTH-1:0]                 w_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0]  w_dest;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_bypass;
  logic                             w_pc_pend_nxt;
  rf_issue_e                        w_issue;
  logic [RF_NUM_REGS-1:0]           w_pend;

  logic [RF_ADDR_W-1:0] r_c;
  logic [DATA_W-1:0]    r_pw;
  logic                 r_rfld;
  logic                 r_pcld;
  logic                 r_pc_pend;

  assign w_push_req.dest = wb.WB_DEST;
  assign w_push_req.data = wb.WB_DATA;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_valid    (w_valid),
    .o_dest     (w_dest)
  );

  always_comb begin
    w_issue = ISSUE_IDLE;
    if (!w_empty)       w_issue = ISSUE_DATA;
    else if (r_pc_pend) w_issue = ISSUE_PC;
  end

  assign w_pop = (w_issue == ISSUE_DATA);

`ifdef RF_WB_BYPASS_EN
  // A registered write already on the port this cycle keeps the port; bypass waits.
  assign w_bypass = w_empty && !r_pc_pend && !r_rfld && wb.WB_VALID;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = wb.WB_VALID && !w_full && !w_bypass;

  // Set after clear: a PC_ADV pulse on the same edge as an R15 issue survives.
  always_comb begin
    w_pc_pend_nxt = r_pc_pend;
    if (w_issue == ISSUE_DATA && w_head.dest == RF_PC_REG) w_pc_pend_nxt = 1'b0;
    if (w_issue == ISSUE_PC)                               w_pc_pend_nxt = 1'b0;
    if (wb.PC_ADV)                                         w_pc_pend_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_c       <= '0;
      r_pw      <= '0;
      r_rfld    <= 1'b0;
      r_pcld    <= 1'b0;
      r_pc_pend <= 1'b0;
    end else begin
      r_pc_pend <= w_pc_pend_nxt;
      case (w_issue)
        ISSUE_DATA: begin
          r_c    <= w_head.dest;
          r_pw   <= w_head.data;
          r_rfld <= 1'b1;
          r_pcld <= 1'b0;
        end
        ISSUE_PC: begin
          r_c    <= RF_PC_REG;
          r_pw   <= '0;
          r_rfld <= 1'b1;
          r_pcld <= 1'b1;
        end
        default: begin
          r_rfld <= 1'b0;
          r_pcld <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) w_pend = w_pend | rf_onehot(w_dest[i]);
    end
  end

  always_comb begin
    wb.WB_READY = !w_full;
    wb.PEND     = w_pend;
    wb.C        = r_c;
    wb.PW       = r_pw;
    wb.RFLd     = r_rfld;
    wb.PCLd     = r_pcld;
    if (w_bypass) begin
      wb.C    = wb.WB_DEST;
      wb.PW   = wb.WB_DATA;
      wb.RFLd = 1'b1;
      wb.PCLd = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_driver.sv
// Directed bench for rf_writeback_driver (default build, registered write port).
module tb_rf_writeback_driver;
  import rf_pkg::*;

  localparam logic [31:0] PCIN = 32'h0000_0104;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;
  logic [31:0] rf [16];

  rf_writeback_driver_if #(.DATA_W(32)) ifc ();

  rf_writeback_driver #(
    .DEPTH  (4),
    .DATA_W (32)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .wb    (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file being driven: R15 takes PCin when PCLd=1.
  always @(posedge CLK) begin
    if (ifc.RFLd) begin
      if (ifc.PCLd) rf[15] <= PCIN;
      else          rf[ifc.C] <= ifc.PW;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.WB_VALID = 1'b0;
    ifc.WB_DEST  = '0;
    ifc.WB_DATA  = '0;
    ifc.PC_ADV   = 1'b0;
  endtask

  task automatic test_reset();
    RST_N        = 1'b0;
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd5;
    ifc.WB_DATA  = 32'd7;
    ifc.PC_ADV   = 1'b1;
    step();
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd} !== 2'b00) begin
      errors++; $display("FAIL reset_ld: RFLd/PCLd got %b want 00", {ifc.RFLd, ifc.PCLd});
    end
    checks++;
    if (ifc.C !== 4'd0 || ifc.PW !== 32'd0) begin
      errors++; $display("FAIL reset_port: C=%0d PW=%0d want 0 0", ifc.C, ifc.PW);
    end
    checks++;
    if (ifc.PEND !== 16'h0000) begin
      errors++; $display("FAIL reset_pend: got %h want 0000", ifc.PEND);
    end
    checks++;
    if (ifc.WB_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ifc.WB_READY);
    end
    idle_inputs();
    RST_N = 1'b1;
    step();
    checks++;
    if (ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL reset_no_stale_write: RFLd got %b want 0", ifc.RFLd);
    end
  endtask

  task automatic test_single_write();
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd3;
    ifc.WB_DATA  = 32'd90;
    step();
    ifc.WB_VALID = 1'b0;
    checks++;
    if (ifc.PEND !== 16'h0008 || ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL single_pend: PEND=%h RFLd=%b want 0008 0", ifc.PEND, ifc.RFLd);
    end
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW} !== {1'b1, 1'b0, 4'd3, 32'd90}) begin
      errors++; $display("FAIL single_issue: RFLd=%b PCLd=%b C=%0d PW=%0d want 1 0 3 90",
                         ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW);
    end
    checks++;
    if (ifc.PEND !== 16'h0000) begin
      errors++; $display("FAIL single_pend_clear: got %h want 0000", ifc.PEND);
    end
    step();
    checks++;
    if (rf[3] !== 32'd90 || ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL single_file: R3=%0d RFLd=%b want 90 0", rf[3], ifc.RFLd);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      ifc.WB_VALID = 1'b1;
      ifc.WB_DEST  = 4'(i + 1);
      ifc.WB_DATA  = 32'((i + 1) * 11);
      step();
      checks++;
      if (ifc.WB_READY !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ifc.WB_READY);
      end
      if (i > 0) begin
        checks++;
        if ({ifc.RFLd, ifc.C, ifc.PW} !== {1'b1, 4'(i), 32'(i * 11)}) begin
          errors++; $display("FAIL b2b_order[%0d]: RFLd=%b C=%0d PW=%0d want 1 %0d %0d",
                             i, ifc.RFLd, ifc.C, ifc.PW, i, i * 11);
        end
      end
    end
    ifc.WB_VALID = 1'b0;
    step();
    checks++;
    if ({ifc.RFLd, ifc.C, ifc.PW} !== {1'b1, 4'd5, 32'd55}) begin
      errors++; $display("FAIL b2b_last: RFLd=%b C=%0d PW=%0d want 1 5 55", ifc.RFLd, ifc.C, ifc.PW);
    end
    step();
    checks++;
    if (ifc.RFLd !== 1'b0 || rf[5] !== 32'd55 || rf[1] !== 32'd11) begin
      errors++; $display("FAIL b2b_drain: RFLd=%b R1=%0d R5=%0d want 0 11 55", ifc.RFLd, rf[1], rf[5]);
    end
  endtask

  task automatic test_pc_adv();
    ifc.PC_ADV = 1'b1;
    step();
    ifc.PC_ADV = 1'b0;
    checks++;
    if (ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL pc_wait: RFLd got %b want 0", ifc.RFLd);
    end
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW} !== {1'b1, 1'b1, 4'd15, 32'd0}) begin
      errors++; $display("FAIL pc_issue: RFLd=%b PCLd=%b C=%0d PW=%0d want 1 1 15 0",
                         ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW);
    end
    step();
    checks++;
    if (rf[15] !== PCIN || ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL pc_file: R15=%h RFLd=%b want %h 0", rf[15], ifc.RFLd, PCIN);
    end
  endtask

  task automatic test_conflict();
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd15;
    ifc.WB_DATA  = 32'd200;
    step();
    ifc.WB_VALID = 1'b0;
    ifc.PC_ADV   = 1'b1;
    step();
    ifc.PC_ADV   = 1'b0;
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW} !== {1'b1, 1'b0, 4'd15, 32'd200}) begin
      errors++; $display("FAIL conflict_data: RFLd=%b PCLd=%b C=%0d PW=%0d want 1 0 15 200",
                         ifc.RFLd, ifc.PCLd, ifc.C, ifc.PW);
    end
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C} !== {1'b1, 1'b1, 4'd15}) begin
      errors++; $display("FAIL conflict_pc_kept: RFLd=%b PCLd=%b C=%0d want 1 1 15",
                         ifc.RFLd, ifc.PCLd, ifc.C);
    end
    step();
    checks++;
    if (ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL conflict_end: RFLd got %b want 0", ifc.RFLd);
    end
  endtask

  task automatic test_supersede();
    // PC_ADV with the R15 push: pending increment is cancelled by the data write.
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd15;
    ifc.WB_DATA  = 32'd300;
    ifc.PC_ADV   = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.PW} !== {1'b1, 1'b0, 32'd300}) begin
      errors++; $display("FAIL supersede_data: RFLd=%b PCLd=%b PW=%0d want 1 0 300",
                         ifc.RFLd, ifc.PCLd, ifc.PW);
    end
    step();
    checks++;
    if (ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL supersede_cleared: RFLd got %b want 0", ifc.RFLd);
    end
  endtask

  task automatic test_coalesce();
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd1;
    ifc.WB_DATA  = 32'd1001;
    ifc.PC_ADV   = 1'b1;
    step();
    ifc.WB_DEST  = 4'd2;
    ifc.WB_DATA  = 32'd1002;
    step();
    idle_inputs();
    checks++;
    if ({ifc.RFLd, ifc.C, ifc.PW} !== {1'b1, 4'd1, 32'd1001}) begin
      errors++; $display("FAIL coalesce_a: RFLd=%b C=%0d PW=%0d want 1 1 1001", ifc.RFLd, ifc.C, ifc.PW);
    end
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C} !== {1'b1, 1'b0, 4'd2}) begin
      errors++; $display("FAIL coalesce_b: RFLd=%b PCLd=%b C=%0d want 1 0 2", ifc.RFLd, ifc.PCLd, ifc.C);
    end
    step();
    checks++;
    if ({ifc.RFLd, ifc.PCLd, ifc.C} !== {1'b1, 1'b1, 4'd15}) begin
      errors++; $display("FAIL coalesce_pc: RFLd=%b PCLd=%b C=%0d want 1 1 15", ifc.RFLd, ifc.PCLd, ifc.C);
    end
    step();
    checks++;
    if (ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL coalesce_single: RFLd got %b want 0", ifc.RFLd);
    end
  endtask

  task automatic test_reset_mid_queue();
    ifc.WB_VALID = 1'b1;
    ifc.WB_DEST  = 4'd4;
    ifc.WB_DATA  = 32'd44;
    step();
    ifc.WB_DEST  = 4'd6;
    ifc.WB_DATA  = 32'd66;
    ifc.PC_ADV   = 1'b1;
    step();
    ifc.WB_DEST  = 4'd7;
    ifc.WB_DATA  = 32'd77;
    ifc.PC_ADV   = 1'b0;
    checks++;
    if (ifc.PEND !== 16'h0040) begin
      errors++; $display("FAIL midrst_pend_before: got %h want 0040", ifc.PEND);
    end
    RST_N = 1'b0;
    step();
    checks++;
    if (ifc.PEND !== 16'h0000 || ifc.RFLd !== 1'b0) begin
      errors++; $display("FAIL midrst_cleared: PEND=%h RFLd=%b want 0000 0", ifc.PEND, ifc.RFLd);
    end
    RST_N = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ifc.RFLd !== 1'b0 || ifc.PEND !== 16'h0000) begin
        errors++; $display("FAIL midrst_quiet[%0d]: RFLd=%b PEND=%h want 0 0000", i, ifc.RFLd, ifc.PEND);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    RST_N = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_pc_adv();
    test_conflict();
    test_supersede();
    test_coalesce();
    test_reset_mid_queue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
